// File: rtl/sensor_protocol_core.sv
// Request/response protocol engine: decodes 2-byte UART requests, triggers one of
// N_SENSORS DHT11 channels, checks the frame checksum and returns a 1- or 3-byte reply.
module sensor_protocol_core #(
    parameter logic [7:0] ADDRESS     = 8'h00,
    parameter int          N_SENSORS   = 4,
    parameter int          RX_TIMEOUT  = 5_000_000,
    parameter int          DTH_TIMEOUT = 50_000_000
) (
    input  logic                      i_Clock,
    input  logic                      i_Rst_n,
    input  logic [7:0]                i_Rx_Data,
    input  logic                      i_Rx_Done,
    input  logic [40*N_SENSORS-1:0]   i_Dth_Data,
    input  logic [N_SENSORS-1:0]      i_Dth_Done,
    input  logic [N_SENSORS-1:0]      i_Dth_Error,
    input  logic                      i_Tx_Done,
    output logic [7:0]                o_Tx_Data,
    output logic                      o_Tx_Start,
    output logic [N_SENSORS-1:0]      o_Dth_Start,
    output logic                      o_Busy
);

    localparam int RX_TW  = $clog2(RX_TIMEOUT + 1);
    localparam int DTH_TW = $clog2(DTH_TIMEOUT + 1);

    localparam logic [7:0] RESP_OK      = 8'h00;
    localparam logic [7:0] RESP_HUM     = 8'h01;
    localparam logic [7:0] RESP_TEMP    = 8'h02;
    localparam logic [7:0] RESP_DTH_ERR = 8'h1f;
    localparam logic [7:0] RESP_CMD_ERR = 8'h2f;
    localparam logic [7:0] RESP_IDX_ERR = 8'h3f;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_SKIP,
        S_RX_CMD,
        S_DECODE,
        S_DTH_START,
        S_DTH_WAIT,
        S_TX_LOAD,
        S_TX_WAIT
    } state_t;

    state_t                 state_reg, state_next;
    logic                   rx_done_prev_reg;
    logic [RX_TW-1:0]       rx_timer_reg, rx_timer_next;
    logic [DTH_TW-1:0]      dth_timer_reg, dth_timer_next;
    logic [7:0]             cmd_reg, cmd_next;
    logic [7:0]             resp_reg [4];
    logic [7:0]             resp_next [4];
    logic [1:0]             resp_len_reg, resp_len_next;
    logic [1:0]             resp_idx_reg, resp_idx_next;
    logic [7:0]             tx_data_reg, tx_data_next;
    logic                   tx_start_reg, tx_start_next;
    logic [N_SENSORS-1:0]   dth_start_reg, dth_start_next;

    logic                   rx_accept;
    logic [39:0]            dth_frame [N_SENSORS];
    logic [N_SENSORS-1:0]   dth_onehot;
    logic [39:0]            sel_frame;
    logic                   sel_done;
    logic                   sel_err;
    logic [7:0]             frame_sum;
    logic                   frame_ok;
    logic                   opcode_ok;
    logic                   index_ok;
    logic                   rx_expired;
    logic                   dth_expired;

    // Only the rising edge of the level-style receive flag counts as a new byte.
    assign rx_accept = i_Rx_Done & ~rx_done_prev_reg;

    generate
        for (genvar gi = 0; gi < N_SENSORS; gi++) begin : g_chan
            assign dth_frame[gi]  = i_Dth_Data[40*gi +: 40];
            assign dth_onehot[gi] = (cmd_reg[7:4] == 4'(gi));
        end
    endgenerate

    always_comb begin
        sel_frame = '0;
        sel_done  = 1'b0;
        sel_err   = 1'b0;
        for (int i = 0; i < N_SENSORS; i++) begin
            if (cmd_reg[7:4] == 4'(i)) begin
                sel_frame = dth_frame[i];
                sel_done  = i_Dth_Done[i];
                sel_err   = i_Dth_Error[i];
            end
        end
    end

    assign frame_sum   = sel_frame[39:32] + sel_frame[31:24] + sel_frame[23:16] + sel_frame[15:8];
    assign frame_ok    = (frame_sum == sel_frame[7:0]);
    assign opcode_ok   = (cmd_reg[3:0] == 4'd3) || (cmd_reg[3:0] == 4'd4) || (cmd_reg[3:0] == 4'd5);
    assign index_ok    = ({28'd0, cmd_reg[7:4]} < 32'(N_SENSORS));
    assign rx_expired  = (rx_timer_reg == RX_TW'(RX_TIMEOUT));
    assign dth_expired = (dth_timer_reg == DTH_TW'(DTH_TIMEOUT));

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state_reg        <= S_IDLE;
            rx_done_prev_reg <= 1'b0;
            rx_timer_reg     <= '0;
            dth_timer_reg    <= '0;
            cmd_reg          <= '0;
            resp_reg         <= '{default: '0};
            resp_len_reg     <= '0;
            resp_idx_reg     <= '0;
            tx_data_reg      <= '0;
            tx_start_reg     <= 1'b0;
            dth_start_reg    <= '0;
        end else begin
            state_reg        <= state_next;
            rx_done_prev_reg <= i_Rx_Done;
            rx_timer_reg     <= rx_timer_next;
            dth_timer_reg    <= dth_timer_next;
            cmd_reg          <= cmd_next;
            resp_reg         <= resp_next;
            resp_len_reg     <= resp_len_next;
            resp_idx_reg     <= resp_idx_next;
            tx_data_reg      <= tx_data_next;
            tx_start_reg     <= tx_start_next;
            dth_start_reg    <= dth_start_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rx_timer_next  = rx_timer_reg;
        dth_timer_next = dth_timer_reg;
        cmd_next       = cmd_reg;
        resp_next      = resp_reg;
        resp_len_next  = resp_len_reg;
        resp_idx_next  = resp_idx_reg;
        tx_data_next   = tx_data_reg;
        tx_start_next  = 1'b0;
        dth_start_next = '0;

        case (state_reg)
            S_IDLE: begin
                rx_timer_next = '0;
                if (rx_accept) begin
                    state_next = (i_Rx_Data == ADDRESS) ? S_RX_CMD : S_RX_SKIP;
                end
            end

            S_RX_SKIP: begin
                if (rx_accept || rx_expired) begin
                    state_next    = S_IDLE;
                    rx_timer_next = '0;
                end else begin
                    rx_timer_next = rx_timer_reg + RX_TW'(1);
                end
            end

            S_RX_CMD: begin
                if (rx_accept) begin
                    cmd_next      = i_Rx_Data;
                    rx_timer_next = '0;
                    state_next    = S_DECODE;
                end else if (rx_expired) begin
                    rx_timer_next = '0;
                    state_next    = S_IDLE;
                end else begin
                    rx_timer_next = rx_timer_reg + RX_TW'(1);
                end
            end

            S_DECODE: begin
                resp_idx_next = '0;
                if (!opcode_ok) begin
                    resp_next[0]  = RESP_CMD_ERR;
                    resp_len_next = 2'd1;
                    state_next    = S_TX_LOAD;
                end else if (!index_ok) begin
                    resp_next[0]  = RESP_IDX_ERR;
                    resp_len_next = 2'd1;
                    state_next    = S_TX_LOAD;
                end else begin
                    state_next    = S_DTH_START;
                end
            end

            S_DTH_START: begin
                dth_start_next = dth_onehot;
                dth_timer_next = '0;
                state_next     = S_DTH_WAIT;
            end

            // Error outranks Done, so a simultaneous Error+Done reports a fault.
            S_DTH_WAIT: begin
                if (sel_err || (sel_done && !frame_ok) || dth_expired) begin
                    resp_next[0]  = RESP_DTH_ERR;
                    resp_len_next = 2'd1;
                    state_next    = S_TX_LOAD;
                end else if (sel_done) begin
                    state_next = S_TX_LOAD;
                    case (cmd_reg[3:0])
                        4'd4: begin
                            resp_next[0]  = RESP_TEMP;
                            resp_next[1]  = sel_frame[23:16];
                            resp_next[2]  = sel_frame[15:8];
                            resp_len_next = 2'd3;
                        end
                        4'd5: begin
                            resp_next[0]  = RESP_HUM;
                            resp_next[1]  = sel_frame[39:32];
                            resp_next[2]  = sel_frame[31:24];
                            resp_len_next = 2'd3;
                        end
                        default: begin
                            resp_next[0]  = RESP_OK;
                            resp_len_next = 2'd1;
                        end
                    endcase
                end else begin
                    dth_timer_next = dth_timer_reg + DTH_TW'(1);
                end
            end

            S_TX_LOAD: begin
                tx_data_next  = resp_reg[resp_idx_reg];
                tx_start_next = 1'b1;
                resp_idx_next = resp_idx_reg + 2'd1;
                state_next    = S_TX_WAIT;
            end

            S_TX_WAIT: begin
                if (i_Tx_Done) begin
                    if (resp_idx_reg < resp_len_reg) begin
                        state_next = S_TX_LOAD;
                    end else begin
                        tx_data_next = '0;
                        state_next   = S_IDLE;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign o_Tx_Data   = tx_data_reg;
    assign o_Tx_Start  = tx_start_reg;
    assign o_Dth_Start = dth_start_reg;
    assign o_Busy      = !((state_reg == S_IDLE) || (state_reg == S_RX_CMD) || (state_reg == S_RX_SKIP));

endmodule

// File: tb/tb_sensor_protocol_core.sv
// Scoreboard bench for sensor_protocol_core: stimulus queues expected TX bytes and
// sensor start vectors; independent monitors pop and compare as the DUT emits them.
module tb_sensor_protocol_core;

    localparam int N = 4;

    logic              i_Clock = 1'b0;
    logic              i_Rst_n = 1'b0;
    logic [7:0]        i_Rx_Data = '0;
    logic              i_Rx_Done = 1'b0;
    logic [40*N-1:0]   i_Dth_Data = '0;
    logic [N-1:0]      i_Dth_Done = '0;
    logic [N-1:0]      i_Dth_Error = '0;
    logic              i_Tx_Done = 1'b0;
    logic [7:0]        o_Tx_Data;
    logic              o_Tx_Start;
    logic [N-1:0]      o_Dth_Start;
    logic              o_Busy;

    always #5 i_Clock = ~i_Clock;

    sensor_protocol_core #(
        .ADDRESS     (8'h05),
        .N_SENSORS   (N),
        .RX_TIMEOUT  (100),
        .DTH_TIMEOUT (200)
    ) dut (
        .i_Clock     (i_Clock),
        .i_Rst_n     (i_Rst_n),
        .i_Rx_Data   (i_Rx_Data),
        .i_Rx_Done   (i_Rx_Done),
        .i_Dth_Data  (i_Dth_Data),
        .i_Dth_Done  (i_Dth_Done),
        .i_Dth_Error (i_Dth_Error),
        .i_Tx_Done   (i_Tx_Done),
        .o_Tx_Data   (o_Tx_Data),
        .o_Tx_Start  (o_Tx_Start),
        .o_Dth_Start (o_Dth_Start),
        .o_Busy      (o_Busy)
    );

    int          n_tests = 0;
    int          n_fail = 0;
    int          tx_start_count = 0;
    int          tx_delay = 3;
    logic [7:0]  exp_tx [$];
    logic [3:0]  exp_dth [$];
    logic [7:0]  mon_b;
    logic [3:0]  mon_d;
    logic [7:0]  rsp_held;
    bit          rsp_abort;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every TX start and sensor start is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge i_Clock);
            if (o_Tx_Start) begin
                tx_start_count++;
                if (exp_tx.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got byte %h, expected none", o_Tx_Data);
                end else begin
                    mon_b = exp_tx.pop_front();
                    $display("[TB] tx byte %h (expected %h)", o_Tx_Data, mon_b);
                    check("tx_byte", {24'd0, o_Tx_Data}, {24'd0, mon_b});
                end
            end
            if (o_Dth_Start != '0) begin
                if (exp_dth.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL dth_unexpected: got start %b, expected none", o_Dth_Start);
                end else begin
                    mon_d = exp_dth.pop_front();
                    $display("[TB] dth start %b (expected %b)", o_Dth_Start, mon_d);
                    check("dth_start", {28'd0, o_Dth_Start}, {28'd0, mon_d});
                end
            end
        end
    end

    // UART transmitter model: checks the byte is held, then pulses i_Tx_Done.
    initial begin
        forever begin
            @(negedge i_Clock);
            if (o_Tx_Start && i_Rst_n) begin
                rsp_held  = o_Tx_Data;
                rsp_abort = 1'b0;
                for (int i = 0; i < tx_delay; i++) begin
                    @(negedge i_Clock);
                    if (!i_Rst_n) begin
                        rsp_abort = 1'b1;
                        break;
                    end
                    if (i == 0) check("tx_start_one_clock", {31'd0, o_Tx_Start}, 32'd0);
                    check("tx_data_hold", {24'd0, o_Tx_Data}, {24'd0, rsp_held});
                end
                if (!rsp_abort) begin
                    i_Tx_Done = 1'b1;
                    @(negedge i_Clock);
                    i_Tx_Done = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_Clock);
        i_Rx_Data = b;
        i_Rx_Done = 1'b1;
        @(negedge i_Clock);
        i_Rx_Done = 1'b0;
    endtask

    task automatic wait_dth(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge i_Clock);
            if (o_Dth_Start != '0) ok = 1'b1;
        end
        check({name, "_dth_seen"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic sensor_pulse(input int k, input logic [39:0] frame, input bit done, input bit err);
        @(negedge i_Clock);
        i_Dth_Data[40*k +: 40] = frame;
        i_Dth_Done[k]  = done;
        i_Dth_Error[k] = err;
        @(negedge i_Clock);
        i_Dth_Done  = '0;
        i_Dth_Error = '0;
        i_Dth_Data  = '1;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        repeat (3) @(negedge i_Clock);
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (!o_Busy) ok = 1'b1;
            else @(negedge i_Clock);
        end
        repeat (5) @(negedge i_Clock);
        check({name, "_idle"}, {31'd0, ok}, 32'd1);
        check({name, "_tx_drained"}, exp_tx.size(), 32'd0);
        check({name, "_dth_drained"}, exp_dth.size(), 32'd0);
    endtask

    initial begin
        int base;
        bit ok;

        // Reset state
        repeat (3) @(negedge i_Clock);
        check("rst_tx_data", {24'd0, o_Tx_Data}, 32'd0);
        check("rst_tx_start", {31'd0, o_Tx_Start}, 32'd0);
        check("rst_dth_start", {28'd0, o_Dth_Start}, 32'd0);
        check("rst_busy", {31'd0, o_Busy}, 32'd0);
        i_Rst_n = 1'b1;
        @(negedge i_Clock);

        // Temperature read from channel 1
        exp_dth.push_back(4'b0010);
        exp_tx.push_back(8'h02); exp_tx.push_back(8'h19); exp_tx.push_back(8'h05);
        send_byte(8'h05); send_byte(8'h14);
        wait_dth("temp");
        check("temp_busy_wait", {31'd0, o_Busy}, 32'd1);
        sensor_pulse(1, 40'h3C_00_19_05_5A, 1'b1, 1'b0);
        wait_idle("temp");
        check("temp_tx_data_cleared", {24'd0, o_Tx_Data}, 32'd0);

        // Done and Error together on channel 2
        exp_dth.push_back(4'b0100);
        exp_tx.push_back(8'h1f);
        send_byte(8'h05); send_byte(8'h25);
        wait_dth("dual");
        sensor_pulse(2, 40'h3C_00_19_05_5A, 1'b1, 1'b1);
        wait_idle("dual");

        // Bad opcode: 2f with two-clock latency
        exp_tx.push_back(8'h2f);
        send_byte(8'h05); send_byte(8'h07);
        @(negedge i_Clock);
        check("lat2f_early", {31'd0, o_Tx_Start}, 32'd0);
        @(negedge i_Clock);
        check("lat2f_start", {31'd0, o_Tx_Start}, 32'd1);
        check("lat2f_no_dth", {28'd0, o_Dth_Start}, 32'd0);
        wait_idle("cmderr");

        // Sensor index out of range
        exp_tx.push_back(8'h3f);
        send_byte(8'h05); send_byte(8'h54);
        @(negedge i_Clock);
        @(negedge i_Clock);
        check("lat3f_start", {31'd0, o_Tx_Start}, 32'd1);
        wait_idle("idxerr");

        // Foreign address is skipped, then a status request to channel 0
        send_byte(8'h09); send_byte(8'h04);
        repeat (10) @(negedge i_Clock);
        exp_dth.push_back(4'b0001);
        exp_tx.push_back(8'h00);
        send_byte(8'h05); send_byte(8'h03);
        wait_dth("status");
        sensor_pulse(0, 40'h11_22_33_44_AA, 1'b1, 1'b0);
        wait_idle("status");

        // Inter-byte timeout: a lone address byte is abandoned
        send_byte(8'h05);
        @(negedge i_Clock);
        check("rxcmd_not_busy", {31'd0, o_Busy}, 32'd0);
        repeat (110) @(negedge i_Clock);
        exp_tx.push_back(8'h3f);
        send_byte(8'h05); send_byte(8'h45);
        wait_idle("rxto");

        // Silent sensor times out; a byte arriving while busy is dropped
        exp_dth.push_back(4'b1000);
        exp_tx.push_back(8'h1f);
        send_byte(8'h05); send_byte(8'h34);
        wait_dth("dthto");
        repeat (50) @(negedge i_Clock);
        send_byte(8'h05);
        repeat (100) @(negedge i_Clock);
        check("dthto_still_busy", {31'd0, o_Busy}, 32'd1);
        check("dthto_not_yet", exp_tx.size(), 32'd1);
        wait_idle("dthto");

        // Bad checksum
        exp_dth.push_back(4'b0010);
        exp_tx.push_back(8'h1f);
        send_byte(8'h05); send_byte(8'h15);
        wait_dth("cksum");
        sensor_pulse(1, 40'h3C_00_19_05_5B, 1'b1, 1'b0);
        wait_idle("cksum");

        // Humidity read from channel 0
        exp_dth.push_back(4'b0001);
        exp_tx.push_back(8'h01); exp_tx.push_back(8'h3C); exp_tx.push_back(8'h07);
        send_byte(8'h05); send_byte(8'h05);
        wait_dth("hum");
        sensor_pulse(0, 40'h3C_07_19_05_61, 1'b1, 1'b0);
        wait_idle("hum");

        // Another channel's Done is ignored
        exp_dth.push_back(4'b0010);
        exp_tx.push_back(8'h00);
        send_byte(8'h05); send_byte(8'h13);
        wait_dth("other");
        sensor_pulse(2, 40'h11_22_33_44_AA, 1'b1, 1'b0);
        @(negedge i_Clock);
        check("other_still_busy", {31'd0, o_Busy}, 32'd1);
        check("other_no_tx", exp_tx.size(), 32'd1);
        sensor_pulse(1, 40'h11_22_33_44_AA, 1'b1, 1'b0);
        wait_idle("other");

        // Reset during the second byte of a 3-byte response
        tx_delay = 20;
        exp_dth.push_back(4'b0010);
        exp_tx.push_back(8'h02); exp_tx.push_back(8'h19);
        base = tx_start_count;
        send_byte(8'h05); send_byte(8'h14);
        wait_dth("rst");
        sensor_pulse(1, 40'h3C_00_19_05_5A, 1'b1, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge i_Clock);
            if (tx_start_count >= base + 2) ok = 1'b1;
        end
        check("rst_second_byte_seen", {31'd0, ok}, 32'd1);
        @(negedge i_Clock);
        i_Rst_n = 1'b0;
        @(negedge i_Clock);
        check("midrst_tx_data", {24'd0, o_Tx_Data}, 32'd0);
        check("midrst_tx_start", {31'd0, o_Tx_Start}, 32'd0);
        check("midrst_dth_start", {28'd0, o_Dth_Start}, 32'd0);
        check("midrst_busy", {31'd0, o_Busy}, 32'd0);
        @(negedge i_Clock);
        i_Rst_n = 1'b1;
        tx_delay = 3;
        repeat (40) @(negedge i_Clock);
        check("midrst_tx_drained", exp_tx.size(), 32'd0);

        // Fresh request after reset completes normally
        exp_dth.push_back(4'b0001);
        exp_tx.push_back(8'h00);
        send_byte(8'h05); send_byte(8'h03);
        wait_dth("post");
        sensor_pulse(0, 40'h11_22_33_44_AA, 1'b1, 1'b0);
        wait_idle("post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_protocol_core.md
Name: sensor_protocol_core

Overview:
- Parametrised successor of the single-sensor protocol FSM. Serves up to N_SENSORS DHT11 channels behind one UART link.
- Decodes 2-byte requests (address, command), triggers the selected sensor and verifies its checksum.
- Returns a 1- or 3-byte response through the UART transmitter.
- Adds inter-byte and sensor-response timeouts, multi-byte TX sequencing and a busy flag.

Parameters:
- ADDRESS, 8'h00, board address compared against the first request byte.
- N_SENSORS, 4, number of DHT11 channels (1..16).
- RX_TIMEOUT, 5_000_000, max clocks between address byte and command byte.
- DTH_TIMEOUT, 50_000_000, max clocks from o_Dth_Start to i_Dth_Done/i_Dth_Error.

Ports:
- i_Clock  in  1  system clock
- i_Rst_n  in  1  reset; one clock, reset is synchronous and active-low
- i_Rx_Data  in  8  UART received byte, valid while i_Rx_Done high
- i_Rx_Done  in  1  UART receive done (level); a byte is accepted on its 0->1 transition only
- i_Dth_Data  in  40*N_SENSORS  channel k occupies bits [40k+39:40k]
- i_Dth_Done  in  N_SENSORS  per-channel read complete (pulse or level)
- i_Dth_Error  in  N_SENSORS  per-channel sensor fault
- i_Tx_Done  in  1  UART transmit done pulse
- o_Tx_Data  out  8  byte to transmit; stable from o_Tx_Start until i_Tx_Done
- o_Tx_Start  out  1  one-clock start pulse to the UART transmitter
- o_Dth_Start  out  N_SENSORS  one-hot, one-clock start pulse to channel k
- o_Busy  out  1  high in every state except IDLE, RX_CMD and RX_SKIP

Behaviour:
- Reset (i_Rst_n=0 at a clock edge, at any time): state IDLE; o_Tx_Data=0, o_Tx_Start=0, o_Dth_Start=0, o_Busy=0; timers, edge register and latched command cleared. Any in-flight transfer is abandoned.
- Command byte format: [7:4] = sensor index k, [3:0] = opcode.
  - 3: status
  - 4: temperature
  - 5: humidity
- Response codes:
  - 8'h00 sensor OK
  - 8'h01 humidity
  - 8'h02 temperature
  - 8'h1f sensor error
  - 8'h2f command error
  - 8'h3f sensor index error
- DHT frame layout: [39:32] humidity integral, [31:24] humidity decimal, [23:16] temperature integral, [15:8] temperature decimal, [7:0] checksum. The frame is valid iff the 8-bit wraparound sum of the four data bytes equals the checksum.
- IDLE: on an accepted byte, go to RX_CMD if the byte == ADDRESS, else RX_SKIP. The inter-byte timer clears on each accepted byte.
- RX_SKIP: the next accepted byte is discarded and the FSM returns to IDLE. Timer expiry (count == RX_TIMEOUT) also returns to IDLE, silently.
- RX_CMD: an accepted byte is latched and the FSM goes to DECODE. Timer expiry returns to IDLE, no response.
- DECODE (1 clock), checks in this priority order:
  - opcode not in {3,4,5}: queue 1 byte 2f.
  - k >= N_SENSORS: queue 1 byte 3f.
  - otherwise: go to DTH_START.
- DTH_START (1 clock): o_Dth_Start[k]=1; the DTH timer clears; go to DTH_WAIT.
- Latency: o_Dth_Start[k], or o_Tx_Start for a 2f/3f response, rises exactly 2 clocks after the edge at which the command byte's i_Rx_Done is first sampled high.
- DTH_WAIT, evaluated in this priority order:
  - i_Dth_Error[k]=1, or bad checksum on i_Dth_Done[k], or timer == DTH_TIMEOUT: queue 1 byte 1f.
  - i_Dth_Done[k]=1 with good checksum:
    - opcode 3: queue 00.
    - opcode 4: queue 02, temp_int, temp_dec.
    - opcode 5: queue 01, hum_int, hum_dec.
  - Error and Done asserted in the same clock: treated as error (1f).
  - Other channels' Done/Error: ignored.
  - Data bytes are latched at the qualifying edge; later changes on i_Dth_Data do not affect the response.
- TX_LOAD: drive o_Tx_Data = next queued byte; o_Tx_Start=1 for exactly one clock.
- TX_WAIT: hold o_Tx_Data. On i_Tx_Done:
  - more bytes queued: go to TX_LOAD (next o_Tx_Start 1 clock later).
  - queue empty: go to IDLE and set o_Tx_Data=0.
- An i_Tx_Done arriving in any state other than TX_WAIT is ignored.
- Bytes arriving while o_Busy=1 are dropped. The rising-edge detector keeps tracking, so a byte whose i_Rx_Done is already high on return to IDLE is not accepted.

Test Plan:
- ADDRESS=8'h05, N_SENSORS=4: send 05, 14; sensor 1 returns 40'h3C_00_19_05_5A -> o_Dth_Start=4'b0010 pulse; TX 02, 19, 05, each held until i_Tx_Done; then IDLE, o_Busy=0.
- Send 05, 25 with channel 2 asserting Done and Error in the same clock -> single byte 1f.
- Send 05, 07 -> 2f within 2 clocks, no o_Dth_Start. Send 05, 54 -> 3f.
- Send 09, 04 -> no TX and no o_Dth_Start. The following 05, 03 with checksum-correct data -> 00.
- RX_TIMEOUT=100, DTH_TIMEOUT=200: address with no command for 100 clocks -> IDLE, no TX. Sensor silent after start -> 1f at timeout.
- Assert i_Rst_n=0 during TX_WAIT of the second byte of a 3-byte response -> next clock all outputs 0, no further o_Tx_Start; a fresh request then completes normally.
